// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C init sequencer: state encoding, bus field
// widths and the default slave address.
package i2c_pkg;

   localparam int ADDR_W = 7;
   localparam int BYTE_W = 8;

   localparam logic [ADDR_W-1:0] DEFAULT_DEV_ADDR = 7'h68;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT_READY,
      ST_ISSUE,
      ST_WAIT_DONE,
      ST_RELEASE,
      ST_GAP,
      ST_FINISH
   } seq_state_t;

endpackage

// File: rtl/i2c_init_rom.sv
// Register write table for the init sequence: entry idx -> (sub-address, data).
// Indices at or beyond NUM_REGS read as 8'h00/8'h00.
module i2c_init_rom
   import i2c_pkg::*;
#(
   parameter int unsigned NUM_REGS = 4,
   parameter int unsigned IW       = 2
) (
   input  logic [IW-1:0]     idx,
   output logic [BYTE_W-1:0] sub,
   output logic [BYTE_W-1:0] data
);

   logic [31:0] idx_w;
   assign idx_w = 32'(idx);

   always_comb begin
      sub  = '0;
      data = '0;
      if (idx_w < NUM_REGS) begin
         case (idx_w)
            32'd0:   begin sub = 8'h20; data = 8'h0F; end
            32'd1:   begin sub = 8'h23; data = 8'h30; end
            32'd2:   begin sub = 8'h21; data = 8'h00; end
            32'd3:   begin sub = 8'h22; data = 8'h08; end
            default: begin sub = 8'h00; data = 8'h00; end
         endcase
      end
   end

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks the init ROM and drives one single-write I2C master transaction per
// entry: start, wait for done, re-arm the master, then idle for a gap.
module i2c_init_sequencer
   import i2c_pkg::*;
#(
   parameter logic [ADDR_W-1:0] DEV_ADDR       = DEFAULT_DEV_ADDR,
   parameter int unsigned       NUM_REGS       = 4,
   parameter int unsigned       GAP_CYCLES     = 100,
   parameter int unsigned       TIMEOUT_CYCLES = 1000000,
   localparam int unsigned      IW             = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   input  logic              m_ready,
   input  logic              m_done,
   output logic              m_start,
   output logic [ADDR_W-1:0] m_addr,
   output logic [BYTE_W-1:0] m_sub,
   output logic [BYTE_W-1:0] m_data,
   output logic              m_rst,
   output logic              busy,
   output logic              seq_done,
   output logic              seq_err,
   output logic [IW-1:0]     idx
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_REGS - 1);

   seq_state_t        state;
   logic [TW-1:0]     timer;
   logic [GW-1:0]     gap_cnt;
   logic              abort;
   logic [BYTE_W-1:0] rom_sub;
   logic [BYTE_W-1:0] rom_data;

   i2c_init_rom #(
      .NUM_REGS (NUM_REGS),
      .IW       (IW)
   ) u_rom (
      .idx  (idx),
      .sub  (rom_sub),
      .data (rom_data)
   );

   assign m_addr = DEV_ADDR;

   // Master handshake: m_start is a one-cycle pulse issued only after m_ready
   // was seen high; m_done is a level held until the m_rst pulse re-arms it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         m_start  <= 1'b0;
         m_rst    <= 1'b0;
         m_sub    <= '0;
         m_data   <= '0;
         busy     <= 1'b0;
         seq_done <= 1'b0;
         seq_err  <= 1'b0;
         idx      <= '0;
         timer    <= '0;
         gap_cnt  <= '0;
         abort    <= 1'b0;
      end else begin
         m_start <= 1'b0;
         m_rst   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (go) begin
                  idx      <= '0;
                  seq_done <= 1'b0;
                  seq_err  <= 1'b0;
                  abort    <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               m_sub  <= rom_sub;
               m_data <= rom_data;
               state  <= ST_WAIT_READY;
            end
            ST_WAIT_READY: begin
               if (m_ready) begin
                  m_start <= 1'b1;
                  state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               timer <= '0;
               state <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               timer <= timer + TW'(1);
               // done on the final timeout cycle still counts as success
               if (m_done) begin
                  m_rst <= 1'b1;
                  state <= ST_RELEASE;
               end else if (timer == TIMER_LAST) begin
                  abort   <= 1'b1;
                  seq_err <= 1'b1;
                  m_rst   <= 1'b1;
                  state   <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (abort) begin
                  abort <= 1'b0;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  gap_cnt <= '0;
                  state   <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  if (idx == IDX_LAST) begin
                     state <= ST_FINISH;
                  end else begin
                     idx   <= idx + IW'(1);
                     state <= ST_LOAD;
                  end
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            ST_FINISH: begin
               seq_done <= 1'b1;
               busy     <= 1'b0;
               state    <= ST_IDLE;
            end
            default: begin
               abort <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Bench for i2c_init_sequencer: three configurations (normal, short timeout,
// single-entry) driven by a reactive master model, checked against a timeline model.
module tb_i2c_init_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [2:0]      rst = '1;
   logic [2:0]      go  = '0;
   logic [2:0]      m_start, m_rst, busy, seq_done, seq_err;
   logic [2:0][6:0] m_addr;
   logic [2:0][7:0] m_sub, m_data, idx_o;

   int hold_until[3] = '{0, 0, 0};
   int dly_arr[3][4];

   int  n_vec = 0;
   int  n_err = 0;
   int  st_cnt, rs_cnt, sd_rise;
   bit  prev_sd;
   bit  spam_on = 1'b0;

   logic [15:0] exp_q[$];
   logic [7:0]  tab_sub[4]  = '{8'h20, 8'h23, 8'h21, 8'h22};
   logic [7:0]  tab_data[4] = '{8'h0F, 8'h30, 8'h00, 8'h08};

   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int unsigned NR = (k == 2) ? 1 : 4;
      localparam int unsigned GP = (k == 2) ? 1 : 4;
      localparam int unsigned TO = (k == 0) ? 200 : ((k == 1) ? 20 : 8);
      localparam int unsigned IW = (NR > 1) ? $clog2(NR) : 1;

      logic          m_ready_l = 1'b1;
      logic          m_done_l  = 1'b0;
      logic [IW-1:0] idx_l;
      bit            mbusy = 1'b0;
      int            cnt   = 0;

      i2c_init_sequencer #(
         .DEV_ADDR       (7'h68),
         .NUM_REGS       (NR),
         .GAP_CYCLES     (GP),
         .TIMEOUT_CYCLES (TO)
      ) u_dut (
         .clk      (clk),
         .reset    (rst[k]),
         .go       (go[k]),
         .m_ready  (m_ready_l),
         .m_done   (m_done_l),
         .m_start  (m_start[k]),
         .m_addr   (m_addr[k]),
         .m_sub    (m_sub[k]),
         .m_data   (m_data[k]),
         .m_rst    (m_rst[k]),
         .busy     (busy[k]),
         .seq_done (seq_done[k]),
         .seq_err  (seq_err[k]),
         .idx      (idx_l)
      );

      assign idx_o[k] = 8'(idx_l);

      // Master model: busy from start until re-armed, done after dly_arr cycles.
      always @(negedge clk) begin
         if (rst[k] || m_rst[k]) begin
            mbusy    = 1'b0;
            m_done_l = 1'b0;
         end else if (m_start[k]) begin
            mbusy = 1'b1;
            cnt   = dly_arr[k][idx_l];
         end else if (mbusy && !m_done_l) begin
            if (cnt == 0) m_done_l = 1'b1;
            else          cnt--;
         end
         m_ready_l = !mbusy && (cyc >= hold_until[k]);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   task automatic tick(input int k);
      @(negedge clk);
      if (m_start[k]) st_cnt++;
      if (m_rst[k])   rs_cnt++;
      if (seq_done[k] && !prev_sd) sd_rise++;
      prev_sd = seq_done[k];
      go[k] = spam_on && ($urandom_range(2, 0) == 0);
   endtask

   task automatic set_dly(input int k, input int lo, input int hi);
      for (int j = 0; j < 4; j++) dly_arr[k][j] = int'($urandom_range(hi, lo));
   endtask

   task automatic check_reset(input int k, input string nm);
      chk($sformatf("d%0d_%s_m_start", k, nm),  32'(m_start[k]),  32'd0);
      chk($sformatf("d%0d_%s_m_rst", k, nm),    32'(m_rst[k]),    32'd0);
      chk($sformatf("d%0d_%s_m_sub", k, nm),    32'(m_sub[k]),    32'd0);
      chk($sformatf("d%0d_%s_m_data", k, nm),   32'(m_data[k]),   32'd0);
      chk($sformatf("d%0d_%s_busy", k, nm),     32'(busy[k]),     32'd0);
      chk($sformatf("d%0d_%s_seq_done", k, nm), 32'(seq_done[k]), 32'd0);
      chk($sformatf("d%0d_%s_seq_err", k, nm),  32'(seq_err[k]),  32'd0);
      chk($sformatf("d%0d_%s_idx", k, nm),      32'(idx_o[k]),    32'd0);
      chk($sformatf("d%0d_%s_m_addr", k, nm),   32'(m_addr[k]),   32'h68);
   endtask

   // One go request; expected cycle of every pulse follows from table size,
   // gap, timeout and the master's done delay.
   task automatic run_table(input int k, input int n, input int g, input int t,
                            input bit spam_en, input int hold_j, input int hold_len,
                            input int rst_j);
      int s, r, l, d;
      logic [15:0] e;
      exp_q.delete();
      for (int j = 0; j < n; j++) exp_q.push_back({tab_sub[j], tab_data[j]});
      st_cnt = 0; rs_cnt = 0; sd_rise = 0; prev_sd = 1'b1;
      tick(k);
      go[k] = 1'b1;
      l = cyc + 1;
      if (hold_j == 0) hold_until[k] = l + hold_len;
      tick(k);
      chk($sformatf("d%0d_load_busy", k),     32'(busy[k]),     32'd1);
      chk($sformatf("d%0d_load_seq_done", k), 32'(seq_done[k]), 32'd0);
      chk($sformatf("d%0d_load_seq_err", k),  32'(seq_err[k]),  32'd0);
      chk($sformatf("d%0d_load_idx", k),      32'(idx_o[k]),    32'd0);
      spam_on = spam_en;
      r = 0;
      for (int j = 0; j < n; j++) begin
         s = l + 2;
         if (hold_j == j && hold_until[k] + 1 > s) s = hold_until[k] + 1;
         while (cyc < s) tick(k);
         e = exp_q.pop_front();
         chk($sformatf("d%0d_e%0d_start", k, j),     32'(m_start[k]), 32'd1);
         chk($sformatf("d%0d_e%0d_start_cnt", k, j), st_cnt,          j + 1);
         chk($sformatf("d%0d_e%0d_sub", k, j),       32'(m_sub[k]),   32'(e[15:8]));
         chk($sformatf("d%0d_e%0d_data", k, j),      32'(m_data[k]),  32'(e[7:0]));
         chk($sformatf("d%0d_e%0d_idx", k, j),       32'(idx_o[k]),   j);
         chk($sformatf("d%0d_e%0d_addr", k, j),      32'(m_addr[k]),  32'h68);
         if (j == rst_j) begin
            spam_on = 1'b0;
            while (cyc < s + 5) tick(k);
            rst[k] = 1'b1;
            tick(k);
            check_reset(k, "midrst");
            rst[k] = 1'b0;
            repeat (4) tick(k);
            chk($sformatf("d%0d_midrst_rst_cnt", k), rs_cnt, j);
            exp_q.delete();
            return;
         end
         d = dly_arr[k][j];
         r = s + 2 + ((d >= t) ? t - 1 : d);
         while (cyc < r) tick(k);
         chk($sformatf("d%0d_e%0d_m_rst", k, j),   32'(m_rst[k]), 32'd1);
         chk($sformatf("d%0d_e%0d_rst_cnt", k, j), rs_cnt,        j + 1);
         if (d >= t) begin
            spam_on = 1'b0;
            tick(k);
            chk($sformatf("d%0d_abort_seq_err", k),  32'(seq_err[k]),  32'd1);
            chk($sformatf("d%0d_abort_busy", k),     32'(busy[k]),     32'd0);
            chk($sformatf("d%0d_abort_idx", k),      32'(idx_o[k]),    j);
            chk($sformatf("d%0d_abort_seq_done", k), 32'(seq_done[k]), 32'd0);
            exp_q.delete();
            return;
         end
         l = r + g + 1;
         if (hold_j == j + 1) hold_until[k] = l + hold_len;
      end
      spam_on = 1'b0;
      while (cyc < r + g + 2) tick(k);
      chk($sformatf("d%0d_end_seq_done", k), 32'(seq_done[k]), 32'd1);
      chk($sformatf("d%0d_end_seq_err", k),  32'(seq_err[k]),  32'd0);
      chk($sformatf("d%0d_end_busy", k),     32'(busy[k]),     32'd0);
      chk($sformatf("d%0d_end_idx", k),      32'(idx_o[k]),    n - 1);
      chk($sformatf("d%0d_end_queue", k),    exp_q.size(),     32'd0);
      repeat (3) tick(k);
      chk($sformatf("d%0d_total_starts", k), st_cnt,  n);
      chk($sformatf("d%0d_total_rsts", k),   rs_cnt,  n);
      chk($sformatf("d%0d_done_rises", k),   sd_rise, 32'd1);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) set_dly(k, 10, 60);
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) check_reset(k, "por");
      rst = '0;

      // normal runs, one entry with the 50-cycle master
      dly_arr[0][$urandom_range(3, 0)] = 49;
      run_table(0, 4, 4, 200, 1'b0, -1, 0, -1);
      set_dly(0, 0, 40);
      run_table(0, 4, 4, 200, 1'b1, -1, 0, -1);
      set_dly(0, 0, 20);
      run_table(0, 4, 4, 200, 1'b0, int'($urandom_range(3, 0)), 30, -1);
      set_dly(0, 10, 30);
      dly_arr[0][2] = 40;
      run_table(0, 4, 4, 200, 1'b0, -1, 0, 2);
      set_dly(0, 0, 30);
      run_table(0, 4, 4, 200, 1'b0, -1, 0, -1);

      // timeout: silent master, then recovery, then abort at a random entry
      set_dly(1, 1000000, 1000000);
      run_table(1, 4, 4, 20, 1'b0, -1, 0, -1);
      set_dly(1, 0, 19);
      run_table(1, 4, 4, 20, 1'b0, -1, 0, -1);
      set_dly(1, 0, 19);
      dly_arr[1][$urandom_range(3, 0)] = 20;
      run_table(1, 4, 4, 20, 1'b0, -1, 0, -1);

      // single entry: done on the timeout cycle, one cycle late, then random
      dly_arr[2][0] = 7;
      run_table(2, 1, 1, 8, 1'b0, -1, 0, -1);
      dly_arr[2][0] = 8;
      run_table(2, 1, 1, 8, 1'b0, -1, 0, -1);
      dly_arr[2][0] = int'($urandom_range(7, 0));
      run_table(2, 1, 1, 8, 1'b1, -1, 0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/i2c_init_sequencer.md
Name: i2c_init_sequencer

Overview:
- Upstream command source for the single-write I2C master. Walks a fixed table of (sub-address, data) register writes for one slave device.
- Handshake per entry: issue start when the master is ready, wait for done, then pulse a master-local reset to re-arm it.
- The master holds in STOP after done; m_rst returns it to IDLE.
- Used for power-up configuration of sensors and codecs; sits between top-level control and the I2C master.

Parameters:
- DEV_ADDR, 7'h68, 7-bit slave address driven on m_addr for every entry.
- NUM_REGS, 4, number of table entries; legal range 1..256.
- GAP_CYCLES, 100, idle clk cycles between m_rst and the next entry's load; legal range 1..65535.
- TIMEOUT_CYCLES, 1000000, maximum clk cycles in WAIT_DONE before abort; minimum 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- go  in  1  single-cycle request to run the whole table; sampled in IDLE only
- m_ready  in  1  master idle and accepting start
- m_done  in  1  master finished the current write (level, held until master reset)
- m_start  out  1  one-cycle start pulse to master
- m_addr  out  7  slave address (= DEV_ADDR)
- m_sub  out  8  register sub-address of current entry
- m_data  out  8  data byte of current entry
- m_rst  out  1  one-cycle master re-arm pulse; OR'ed with global reset at integration
- busy  out  1  high in any state other than IDLE
- seq_done  out  1  sticky: table completed; cleared by accepted go or reset
- seq_err  out  1  sticky: timeout abort; cleared by accepted go or reset
- idx  out  IW  current entry index, IW = max(1, $clog2(NUM_REGS))

Behaviour:
- Reset values: m_start=0, m_rst=0, m_sub=0, m_data=0, busy=0, seq_done=0, seq_err=0, idx=0, state=IDLE, timers=0. m_addr is constant DEV_ADDR.
- All outputs registered; only state/counters drive them.
- IDLE: go=1 -> idx<=0, seq_done<=0, seq_err<=0, next LOAD. go is ignored in all other states (no queuing).
- LOAD (1 cycle): m_sub/m_data <= table[idx] -> WAIT_READY.
- WAIT_READY: stays until m_ready=1 (no timeout) -> ISSUE.
- ISSUE (1 cycle): m_start=1; timer<=0 -> WAIT_DONE.
  - Latency go -> m_start is 3 cycles minimum: LOAD, WAIT_READY with m_ready already high, then ISSUE.
- WAIT_DONE: timer increments each cycle.
  - m_done=1 -> RELEASE.
  - Else timer==TIMEOUT_CYCLES-1 -> abort flag set, seq_err<=1, -> RELEASE.
  - m_done on the same cycle as the timeout wins: no error.
- RELEASE (1 cycle): m_rst=1.
  - Abort flag set -> IDLE (idx holds the failed entry).
  - Otherwise -> GAP with gap counter 0.
- GAP: counts GAP_CYCLES cycles.
  - At count GAP_CYCLES-1: if idx==NUM_REGS-1 -> FINISH; else idx<=idx+1 -> LOAD.
- FINISH (1 cycle): seq_done<=1 -> IDLE; idx holds NUM_REGS-1.
- m_sub/m_data hold their last value outside LOAD.
- Reset mid-operation: immediate return to reset values.
  - No m_rst pulse is generated; global reset covers the master.
- Counter widths: timer $clog2(TIMEOUT_CYCLES+1) bits, gap $clog2(GAP_CYCLES+1) bits. idx compare is exact, with no wrap past NUM_REGS-1.
- Unreachable state encodings -> IDLE.

Decomposition:
- Shared package i2c_pkg:
  - state enum for the sequencer.
  - I2C address width (7) and byte width (8) constants.
  - default DEV_ADDR.
- Sub-module i2c_init_rom:
  - parameter NUM_REGS; input idx; outputs sub[7:0], data[7:0].
  - combinational case table; out-of-range index returns 8'h00/8'h00.
  - default content {8'h20,8'h0F},{8'h23,8'h30},{8'h21,8'h00},{8'h22,8'h08}.

Test Plan:
- Normal run, NUM_REGS=4, GAP_CYCLES=4, master model asserts m_done 50 cycles after m_start -> exactly 4 m_start pulses.
  - m_sub sequence 20,23,21,22 with data 0F,30,00,08; 4 m_rst pulses, each the cycle after m_done seen.
  - seq_done=1, seq_err=0, busy=0 at end.
- Timeout, TIMEOUT_CYCLES=20, master never asserts m_done -> m_start once, m_rst exactly 20 cycles later +1.
  - seq_err=1, idx=0, IDLE; next go clears seq_err and restarts at idx=0.
- m_ready held low 30 cycles after LOAD -> m_start asserted the cycle after m_ready rises, never earlier.
- go pulsed repeatedly while busy -> ignored: still exactly NUM_REGS transactions, and seq_done pulse occurs once.
- reset asserted in WAIT_DONE of entry 2 -> next cycle all outputs at reset values, no m_rst pulse; subsequent go runs from idx=0.
- Boundary NUM_REGS=1, GAP_CYCLES=1, m_done simultaneous with timeout cycle -> one transaction, seq_done=1, seq_err=0, IW=1.
